// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit_if : instruction-memory, redirect and decode-side signal bundle |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instruccion;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready;

    modport master (
        output imem_req, imem_addr, instruccion, pc_out, valid,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ready
    );

    modport slave (
        input  imem_req, imem_addr, instruccion, pc_out, valid,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_unit : RV32I fetch stage - PC, imem request/response, output FIFO    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    fetch_unit_if.master  bus
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);
    localparam logic [31:0] C_NOP   = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [31:0]   r_fifo_data [DEPTH];
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_ifq_pc    [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_ifq_wr;
    logic [PW-1:0] r_ifq_rd;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_discard;
    logic          r_run;

    logic          w_req;
    logic          w_grant;
    logic          w_resp;
    logic          w_keep;
    logic          w_valid;
    logic          w_pop;
    logic [CW:0]   w_used;
    logic          w_unused;

    // Credit covers buffered, in-flight and to-be-dropped words so the FIFO never overflows
    assign w_used   = {1'b0, r_count} + {1'b0, r_inflight} + {1'b0, r_discard};
    assign w_req    = r_run && (w_used < C_DEPTH);
    assign w_grant  = w_req && bus.imem_gnt;
    assign w_resp   = bus.imem_rvalid && ((r_inflight != '0) || (r_discard != '0));
    assign w_keep   = w_resp && (r_discard == '0);
    assign w_valid  = (r_count != '0);
    assign w_pop    = w_valid && bus.ready;
    assign w_unused = ^bus.redirect_pc[1:0];

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.valid       = w_valid;
    assign bus.instruccion = w_valid ? r_fifo_data[r_rd_ptr] : C_NOP;
    assign bus.pc_out      = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ifq_wr   <= '0;
            r_ifq_rd   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_run      <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (bus.redirect) begin
                // Everything granted so far becomes wrong-path; a response this cycle is dropped
                r_pc       <= {bus.redirect_pc[31:2], 2'b00};
                r_discard  <= r_discard + r_inflight + CW'(w_grant) - CW'(w_resp);
                r_inflight <= '0;
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ifq_wr   <= '0;
                r_ifq_rd   <= '0;
            end else begin
                if (w_grant) begin
                    r_pc     <= r_pc + 32'd4;
                    r_ifq_wr <= r_ifq_wr + PW'(1);
                end
                if (w_resp && !w_keep) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_keep) begin
                    r_ifq_rd <= r_ifq_rd + PW'(1);
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_inflight <= r_inflight + CW'(w_grant) - CW'(w_keep);
                r_count    <= r_count + CW'(w_keep) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant && !bus.redirect) begin
            r_ifq_pc[r_ifq_wr] <= r_pc;
        end
        if (w_keep && !bus.redirect) begin
            r_fifo_data[r_wr_ptr] <= bus.imem_rdata;
            r_fifo_pc[r_wr_ptr]   <= r_ifq_pc[r_ifq_rd];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench for fetch_unit with a latency-model imem  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam int          C_DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(C_RESET_PC), .DEPTH(C_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          n_pops   = 0;
    int          first_gnt = -1;
    int          first_vld = -1;
    logic        gnt_v = 1'b1;
    logic        rdy_v = 1'b1;
    logic        redir_v = 1'b0;
    logic [31:0] redir_pc_v = 32'h0;
    logic [31:0] exp_pc = C_RESET_PC;
    logic        want_first = 1'b0;
    logic [31:0] first_after = 32'h0;
    mreq_t       mq[$];
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // One clock: drive inputs and model memory on the falling edge, score what the DUT shows
    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        bus.imem_gnt    = gnt_v;
        bus.ready       = rdy_v;
        bus.redirect    = redir_v;
        bus.redirect_pc = redir_pc_v;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mq[0].addr;
            void'(mq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        if (!rst_n) return;
        if (bus.valid && first_vld < 0) first_vld = cyc;
        if (redir_v) begin
            exp_q.delete();
            want_first = 1'b1;
        end else if (bus.valid && bus.ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("pc_out", bus.pc_out, e);
                check("instruccion", bus.instruccion, e);
                if (want_first) begin
                    first_after = bus.pc_out;
                    want_first  = 1'b0;
                end
            end
        end
        if (bus.imem_req && bus.imem_gnt) begin
            check("grant_addr", bus.imem_addr, exp_pc);
            mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
            if (first_gnt < 0) first_gnt = cyc;
            if (!redir_v) begin
                exp_q.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (redir_v) exp_pc = {redir_pc_v[31:2], 2'b00};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus.imem_req), 32'd0);
        check({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_instr"}, bus.instruccion, 32'h0000_0013);
        check({tag, "_pcout"}, bus.pc_out, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hold;
        int          p0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.ready       = 1'b1;

        // Reset state and startup
        repeat (2) step();
        check_reset_outputs("rst");
        check("rst_addr", bus.imem_addr, C_RESET_PC);
        rst_n = 1'b1;
        step();
        check("start_req", 32'(bus.imem_req), 32'd1);
        check("start_addr", bus.imem_addr, C_RESET_PC);
        repeat (6) step();
        check("latency", 32'(first_vld - first_gnt), 32'd2);

        // Sustained throughput with zero-wait memory
        p0 = n_pops;
        repeat (8) step();
        check("throughput", 32'(n_pops - p0), 32'd8);

        // Grant wait states: address must hold
        gnt_v = 1'b0;
        step();
        hold = bus.imem_addr;
        repeat (2) begin
            step();
            check("wait_addr", bus.imem_addr, hold);
        end
        gnt_v = 1'b1;
        step();
        check("wait_release_addr", bus.imem_addr, hold);
        repeat (6) step();

        // Backpressure: head and valid hold, credit runs out
        rdy_v = 1'b0;
        step();
        hold = bus.pc_out;
        repeat (5) begin
            step();
            check("bp_head", bus.pc_out, hold);
            check("bp_valid", 32'(bus.valid), 32'd1);
        end
        check("bp_req", 32'(bus.imem_req), 32'd0);
        rdy_v = 1'b1;
        repeat (10) step();

        // Redirect with several words in flight (latency 3)
        lat = 3;
        repeat (8) step();
        redir_v    = 1'b1;
        redir_pc_v = 32'h0000_2002;
        step();
        redir_v = 1'b0;
        step();
        check("redir_valid", 32'(bus.valid), 32'd0);
        check("redir_addr", bus.imem_addr, 32'h0000_2000);
        repeat (15) step();
        check("redir_first", first_after, 32'h0000_2000);

        // Redirect coincident with a grant and a pop
        lat = 1;
        repeat (6) step();
        redir_v    = 1'b1;
        redir_pc_v = 32'h0000_3000;
        step();
        check("co_valid", 32'(bus.valid), 32'd1);
        check("co_grant", 32'(bus.imem_req && bus.imem_gnt), 32'd1);
        redir_v = 1'b0;
        step();
        check("co_valid_next", 32'(bus.valid), 32'd0);
        repeat (8) step();
        check("co_first", first_after, 32'h0000_3000);

        // Reset mid-stream with the FIFO full
        rdy_v = 1'b0;
        repeat (8) step();
        check("full_valid", 32'(bus.valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        mq.delete();
        exp_q.delete();
        exp_pc    = C_RESET_PC;
        first_gnt = -1;
        first_vld = -1;
        rdy_v     = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check("restart_addr", bus.imem_addr, C_RESET_PC);
        repeat (10) step();
        check("restart_latency", 32'(first_vld - first_gnt), 32'd2);
        check("pops_seen", 32'(n_pops >= 40), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
